mips_boot_loader: RTL and testbench
===================================

Name: mips_boot_loader

Overview:
- Hardware program loader for the MIPS cores: accepts a framed byte stream and writes bytes into instruction or data memory, one byte per memory location, little-endian order preserved from the stream.
- Holds the CPU in reset until a RUN command arrives, then releases it.
- Sits between a host byte source (UART receiver or bench driver) and the byte-wide write ports of the instruction and data memories.

Parameters:
- ADDR_W, 16, width of the byte address driven to memory; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid & in_ready.
- mem_we  out  1  one-cycle write strobe.
- mem_sel  out  1  0 = instruction memory, 1 = data memory.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  8  byte to write.
- cpu_rst  out  1  reset to the CPU; high until RUN.
- blk_done  out  1  one-cycle pulse when a block's checksum byte is accepted.
- err  out  1  sticky error flag.

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1. mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, cpu_rst=1, blk_done=0, err=0. FSM enters CMD.
- Frame format: CMD, LEN_L, LEN_H, ADR_L, ADR_H, LEN payload bytes, CSUM.
  - CMD 0x01 loads instruction memory.
  - CMD 0x02 loads data memory.
  - CMD 0x03 is RUN and is a single byte with no further fields.
- FSM states: CMD, LEN0, LEN1, ADR0, ADR1, DATA, CSUM, RUN. Each state advances only on an accepted byte.
- CMD state:
  - 0x01 or 0x02: latch sel, go to LEN0.
  - 0x03: go to RUN.
  - Any other value: set err, stay in CMD. The byte is consumed.
- LEN0/LEN1 latch the 16-bit length, LSB first. ADR0/ADR1 latch the base address, LSB first; the address is truncated to ADR_W bits.
- After ADR1, the running sum is cleared.
  - Length = 0: go to CSUM.
  - Otherwise: go to DATA with remaining count = length.
- DATA state, per accepted byte:
  - Registered write: mem_we=1 in the following cycle, with mem_addr = current address, mem_wdata = byte, mem_sel = latched sel.
  - Address increments by 1 and wraps to 0 after 2^ADDR_W-1.
  - Sum is updated as sum + byte, mod 256.
  - Count decrements; after the last byte, go to CSUM.
- Write latency and throughput:
  - Latency from accepted byte to mem_we is exactly 1 cycle.
  - in_ready stays 1 in all receive states, sustaining 1 byte per cycle.
  - mem_we is 0 in every cycle without a preceding accepted DATA byte; gaps in in_valid produce gaps in mem_we.
- CSUM state, on accepted byte:
  - blk_done pulses the next cycle.
  - If byte != sum, set err. Writes already performed are not undone.
  - Return to CMD.
- RUN state:
  - cpu_rst=0 from the cycle after the RUN byte is accepted.
  - in_ready=0; the state is held until rst.
- err is sticky until rst; loading continues normally after an error.
- Reset mid-frame aborts the frame:
  - The next cycle starts in CMD with all outputs at reset values.
  - A mem_we pending from the last accepted byte is suppressed.
  - cpu_rst returns to 1.
- in_valid while in_ready=0 has no effect; no byte is consumed.

Test Plan:
- Load 4 bytes: stream 01 04 00 00 00 20 08 00 05 2D -> mem_we in 4 consecutive cycles, mem_sel=0, addr 0..3, data 20 08 00 05; blk_done pulse; err=0.
- Data load with bad checksum: 02 02 00 10 00 AA 55 00 -> writes AA@0x0010 and 55@0x0011 with mem_sel=1; blk_done pulse; err=1 and stays 1 through a following good frame.
- Wrap-around, ADDR_W=16: 01 03 00 FF FF 01 02 03 06 -> writes at FFFF, 0000, 0001; err=0.
- Zero-length frame and unknown command:
  - 01 00 00 34 12 00 -> no mem_we; blk_done pulse; err=0.
  - Then byte 7F -> err=1; FSM stays in CMD.
- RUN with backpressure gaps:
  - Frame sent with in_valid low for 3 cycles between payload bytes -> mem_we gaps match the input gaps.
  - Then 03 -> cpu_rst falls the next cycle; in_ready=0; further bytes are ignored.
- Reset mid-frame: assert rst after ADR_H and one payload byte -> no mem_we in the cycle after rst; cpu_rst=1; a fresh full frame then loads correctly.

Source files
------------

// File: rtl/mips_boot_loader.sv
// Framed byte-stream program loader for the MIPS cores.
// Decodes CMD/LEN/ADR/payload/CSUM frames, emits registered byte writes to
// instruction or data memory, and holds the CPU in reset until a RUN command.
module mips_boot_loader #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              blk_done,
  output logic              err
);

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;

  typedef enum logic [2:0] {
    S_CMD,
    S_LEN0,
    S_LEN1,
    S_ADR0,
    S_ADR1,
    S_DATA,
    S_CSUM,
    S_RUN
  } state_t;

  state_t state, state_n;

  logic              take;
  logic              cmd_load;
  logic              cmd_run;
  logic              sel_q;
  logic [15:0]       len_q;
  logic [15:0]       cnt_q;
  logic [7:0]        adr_lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        sum_q;

  // Ready in every receive state; low while in reset and once RUN is reached.
  assign in_ready = !rst && (state != S_RUN);
  assign take     = in_valid && in_ready;

  assign cmd_load = (in_data == CMD_IMEM) || (in_data == CMD_DMEM);
  assign cmd_run  = (in_data == CMD_RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_CMD;
    else     state <= state_n;
  end

  // Next-state decode; every transition is gated by an accepted byte.
  always_comb begin
    state_n = state;
    if (take) begin
      case (state)
        S_CMD: begin
          if (cmd_load)     state_n = S_LEN0;
          else if (cmd_run) state_n = S_RUN;
          else              state_n = S_CMD;
        end
        S_LEN0: state_n = S_LEN1;
        S_LEN1: state_n = S_ADR0;
        S_ADR0: state_n = S_ADR1;
        S_ADR1: state_n = (len_q == 16'd0) ? S_CSUM : S_DATA;
        S_DATA: state_n = (cnt_q == 16'd1) ? S_CSUM : S_DATA;
        S_CSUM: state_n = S_CMD;
        S_RUN:  state_n = S_RUN;
        default: state_n = S_CMD;
      endcase
    end
  end

  // Frame fields, running checksum and registered memory write / status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      adr_lo_q  <= '0;
      addr_q    <= '0;
      sum_q     <= '0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      blk_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      blk_done <= 1'b0;
      if (take) begin
        case (state)
          S_CMD: begin
            if (cmd_load)     sel_q   <= in_data[1];
            else if (cmd_run) cpu_rst <= 1'b0;
            else              err     <= 1'b1;
          end
          S_LEN0: len_q[7:0]  <= in_data;
          S_LEN1: len_q[15:8] <= in_data;
          S_ADR0: adr_lo_q    <= in_data;
          S_ADR1: begin
            addr_q <= ADDR_W'({in_data, adr_lo_q});
            sum_q  <= '0;
            cnt_q  <= len_q;
          end
          S_DATA: begin
            mem_we    <= 1'b1;
            mem_sel   <= sel_q;
            mem_addr  <= addr_q;
            mem_wdata <= in_data;
            addr_q    <= addr_q + ADDR_W'(1);
            sum_q     <= sum_q + in_data;
            cnt_q     <= cnt_q - 16'd1;
          end
          S_CSUM: begin
            blk_done <= 1'b1;
            if (in_data != sum_q) err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader: a cycle monitor predicts every mem_we
// and blk_done from the bytes the stimulus marks as payload / checksum.
module tb_mips_boot_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic        mem_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_rst;
  logic        blk_done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // Expectation for the byte currently presented, and for the one before it.
  logic        pay, cs, e_sel;
  logic [15:0] e_addr;
  logic [7:0]  e_data;
  logic        pay_d = 1'b0, cs_d = 1'b0, e_sel_d = 1'b0;
  logic [15:0] e_addr_d = '0;
  logic [7:0]  e_data_d = '0;

  mips_boot_loader #(.ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .blk_done  (blk_done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // kind: 0 = header/ignored byte, 1 = payload byte, 2 = checksum byte
  task automatic send(input logic [7:0] b, input int kind, input logic [15:0] a, input logic s);
    in_data  = b;
    in_valid = 1'b1;
    pay      = (kind == 1);
    cs       = (kind == 2);
    e_addr   = a;
    e_data   = b;
    e_sel    = s;
    @(posedge clk); #1;
  endtask

  task automatic hdr(input logic [7:0] b);
    send(b, 0, 16'h0000, 1'b0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    pay      = 1'b0;
    cs       = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle check: a write follows exactly one cycle after each payload byte,
  // and never otherwise; blk_done follows each checksum byte.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mem_we", mem_we, pay_d);
      if (pay_d) begin
        chk("mem_addr", mem_addr, e_addr_d);
        chk("mem_wdata", mem_wdata, e_data_d);
        chk("mem_sel", mem_sel, e_sel_d);
      end
      chk("blk_done", blk_done, cs_d);
    end
    pay_d    = pay && !rst;
    cs_d     = cs && !rst;
    e_addr_d = e_addr;
    e_data_d = e_data;
    e_sel_d  = e_sel;
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    pay = 1'b0; cs = 1'b0; e_sel = 1'b0; e_addr = '0; e_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // 4-byte instruction load
    hdr(8'h01); hdr(8'h04); hdr(8'h00); hdr(8'h00); hdr(8'h00);
    send(8'h20, 1, 16'h0000, 1'b0);
    send(8'h08, 1, 16'h0001, 1'b0);
    send(8'h00, 1, 16'h0002, 1'b0);
    send(8'h05, 1, 16'h0003, 1'b0);
    send(8'h2D, 2, 16'h0000, 1'b0);
    idle(2);
    chk("load4_err", err, 1'b0);

    // Address wrap-around
    hdr(8'h01); hdr(8'h03); hdr(8'h00); hdr(8'hFF); hdr(8'hFF);
    send(8'h01, 1, 16'hFFFF, 1'b0);
    send(8'h02, 1, 16'h0000, 1'b0);
    send(8'h03, 1, 16'h0001, 1'b0);
    send(8'h06, 2, 16'h0000, 1'b0);
    idle(2);
    chk("wrap_err", err, 1'b0);

    // Zero-length frame
    hdr(8'h01); hdr(8'h00); hdr(8'h00); hdr(8'h34); hdr(8'h12);
    send(8'h00, 2, 16'h0000, 1'b0);
    idle(2);
    chk("zlen_err", err, 1'b0);

    // Unknown command, then a zero-length frame proves the FSM stayed in CMD
    hdr(8'h7F);
    idle(1);
    chk("badcmd_err", err, 1'b1);
    hdr(8'h02); hdr(8'h00); hdr(8'h00); hdr(8'h00); hdr(8'h00);
    send(8'h00, 2, 16'h0000, 1'b0);
    idle(2);
    chk("badcmd_sticky", err, 1'b1);

    // Reset clears the sticky error
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    chk("rst2_err", err, 1'b0);

    // Data load with bad checksum, then a good frame
    hdr(8'h02); hdr(8'h02); hdr(8'h00); hdr(8'h10); hdr(8'h00);
    send(8'hAA, 1, 16'h0010, 1'b1);
    send(8'h55, 1, 16'h0011, 1'b1);
    send(8'h00, 2, 16'h0000, 1'b0);
    idle(1);
    chk("badsum_err", err, 1'b1);
    hdr(8'h02); hdr(8'h01); hdr(8'h00); hdr(8'h20); hdr(8'h00);
    send(8'h11, 1, 16'h0020, 1'b1);
    send(8'h11, 2, 16'h0000, 1'b0);
    idle(2);
    chk("badsum_sticky", err, 1'b1);

    // Reset mid-frame after the header and one payload byte
    hdr(8'h01); hdr(8'h04); hdr(8'h00); hdr(8'h50); hdr(8'h00);
    send(8'h99, 1, 16'h0050, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; pay = 1'b0; cs = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_mem_we", mem_we, 1'b0);
    chk("midrst_cpu_rst", cpu_rst, 1'b1);
    chk("midrst_err", err, 1'b0);
    chk("midrst_mem_addr", mem_addr, 16'h0000);
    hdr(8'h02); hdr(8'h02); hdr(8'h00); hdr(8'h00); hdr(8'h02);
    send(8'hC3, 1, 16'h0200, 1'b1);
    send(8'h3C, 1, 16'h0201, 1'b1);
    send(8'hFF, 2, 16'h0000, 1'b0);
    idle(2);
    chk("fresh_err", err, 1'b0);

    // Payload with 3-cycle valid gaps
    hdr(8'h01); hdr(8'h03); hdr(8'h00); hdr(8'h00); hdr(8'h01);
    send(8'h10, 1, 16'h0100, 1'b0);
    idle(3);
    send(8'h20, 1, 16'h0101, 1'b0);
    idle(3);
    send(8'h30, 1, 16'h0102, 1'b0);
    send(8'h60, 2, 16'h0000, 1'b0);
    idle(2);
    chk("gap_err", err, 1'b0);
    chk("pre_run_cpu_rst", cpu_rst, 1'b1);

    // RUN releases the CPU; later bytes are ignored
    hdr(8'h03);
    chk("run_cpu_rst", cpu_rst, 1'b0);
    chk("run_in_ready", in_ready, 1'b0);
    hdr(8'h7F); hdr(8'h01); hdr(8'h01); hdr(8'h00); hdr(8'h00); hdr(8'h00); hdr(8'hEE);
    idle(2);
    chk("run_hold_cpu_rst", cpu_rst, 1'b0);
    chk("run_hold_in_ready", in_ready, 1'b0);
    chk("run_hold_err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
